burst_dram: RTL and testbench

BURST_DRAM -- requirements
Module: burst_dram

---
 rtl/burst_dram.sv | 158 +++++++++++++++
 tb/tb_burst_dram.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_dram.sv
// Burst-oriented memory model: fixed-length read/write bursts after a fixed access latency.
// Optional DRAM_ALIGN_CHECK_EN rejects requests whose address is not a multiple of BLOCK_SIZE.
module burst_dram #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_is_rd,
  input  logic [31:0]           req_addr,
  input  logic                  wr_vld,
  output logic                  wr_rdy,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  err
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BLOCK_SIZE - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST_RD, BURST_WR} state_t;

  state_t                state;
  logic                  is_rd;
  logic [31:0]           base;
  logic [LW-1:0]         lat_cnt;
  logic [BW-1:0]         beat;
  logic [AW-1:0]         cur_addr;
  logic [AW-1:0]         next_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Address arithmetic is truncated to the memory index width so bursts wrap at the top.
  assign cur_addr  = AW'(base + 32'(beat));
  assign next_addr = AW'(base + 32'(beat) + 32'd1);

`ifdef DRAM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (req_addr % 32'(BLOCK_SIZE)) != 32'd0;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      is_rd   <= 1'b0;
      base    <= '0;
      lat_cnt <= '0;
      beat    <= '0;
      req_rdy <= 1'b1;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      rd_data <= '0;
      wr_rdy  <= 1'b0;
`ifdef DRAM_ALIGN_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
`ifdef DRAM_ALIGN_CHECK_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_vld) begin
`ifdef DRAM_ALIGN_CHECK_EN
            // A rejected request is consumed here and never leaves IDLE.
            if (misaligned) err <= 1'b1;
            else
`endif
            begin
              state   <= WAIT;
              req_rdy <= 1'b0;
              is_rd   <= req_is_rd;
              base    <= req_addr;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            beat <= '0;
            if (is_rd) begin
              state   <= BURST_RD;
              rd_vld  <= 1'b1;
              rd_data <= mem[AW'(base)];
              rd_last <= (LAST_BEAT == '0);
            end else begin
              state  <= BURST_WR;
              wr_rdy <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        BURST_RD: begin
          // Outputs only move on a handshake, so a stalled beat holds by construction.
          if (rd_rdy) begin
            if (beat == LAST_BEAT) begin
              state   <= IDLE;
              req_rdy <= 1'b1;
              rd_vld  <= 1'b0;
              rd_last <= 1'b0;
              rd_data <= '0;
              beat    <= '0;
            end else begin
              beat    <= beat + 1'b1;
              rd_data <= mem[next_addr];
              rd_last <= ((beat + 1'b1) == LAST_BEAT);
            end
          end
        end
        BURST_WR: begin
          if (wr_vld) begin
            if (beat == LAST_BEAT) begin
              state   <= IDLE;
              req_rdy <= 1'b1;
              wr_rdy  <= 1'b0;
              beat    <= '0;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          req_rdy <= 1'b1;
          rd_vld  <= 1'b0;
          rd_last <= 1'b0;
          rd_data <= '0;
          wr_rdy  <= 1'b0;
        end
      endcase
    end
  end

  // Single write port; contents deliberately survive reset, but a reset edge blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_rdy && wr_vld) begin
      mem[cur_addr] <= wr_data;
    end
  end

  a_one_channel: assert property (@(posedge clk) disable iff (rst) !(rd_vld && wr_rdy));
  a_rdy_idle:    assert property (@(posedge clk) disable iff (rst) req_rdy == (state == IDLE));
  a_rd_hold:     assert property (@(posedge clk) disable iff (rst)
                   (rd_vld && !rd_rdy) |=> (rd_vld && $stable(rd_data) && $stable(rd_last)));

endmodule

// File: tb/tb_burst_dram.sv
// Directed self-checking bench for burst_dram at default parameters.
// Covers DRAM_ALIGN_CHECK_EN in both builds through the misaligned-request test.
module tb_burst_dram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic        req_is_rd = 1'b0;
  logic [31:0] req_addr = '0;
  logic        wr_vld = 1'b0;
  logic        wr_rdy;
  logic [7:0]  wr_data = '0;
  logic        rd_vld;
  logic        rd_rdy = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_mem [1024];

  burst_dram dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_is_rd(req_is_rd), .req_addr(req_addr),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_data(rd_data), .rd_last(rd_last),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic is_rd, input int addr, input bit hold);
    int n = 0;
    req_vld   = 1'b1;
    req_is_rd = is_rd;
    req_addr  = 32'(addr);
    while (req_rdy !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL req_accept: req_rdy=%b expected 1", req_rdy);
    end
    tick();
    if (!hold) req_vld = 1'b0;
  endtask

  task automatic wait_latency(input bit rd);
    int n = 0;
    while (((rd ? rd_vld : wr_rdy) !== 1'b1) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("[TB] FAIL latency: first beat after %0d cycles, expected 4 (rd=%0b)", n, rd);
    end
  endtask

  task automatic write_burst(input int base, input int seed, input int gap_beat, input int abort_beat);
    logic [7:0] d;
    issue(1'b0, base, 1'b0);
    checks++;
    if (req_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_after_accept: req_rdy=%b expected 0", req_rdy);
    end
    wait_latency(1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i == gap_beat) begin
        wr_vld  = 1'b0;
        wr_data = 8'hEE;
        for (int g = 0; g < 3; g++) begin
          checks++;
          if (wr_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_gap_rdy: wr_rdy=%b expected 1", wr_rdy);
          end
          tick();
        end
      end
      d       = 8'(seed + i);
      wr_vld  = 1'b1;
      wr_data = d;
      if (i == abort_beat) begin
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        wr_vld = 1'b0;
        checks++;
        if (req_rdy !== 1'b1 || wr_rdy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL abort_idle: req_rdy=%b wr_rdy=%b expected 1 0", req_rdy, wr_rdy);
        end
        return;
      end
      checks++;
      if (wr_rdy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL wr_beat_rdy: beat %0d wr_rdy=%b expected 1", i, wr_rdy);
      end
      tick();
      exp_mem[(base + i) % 1024] = d;
    end
    wr_vld = 1'b0;
    checks++;
    if (wr_rdy !== 1'b0 || req_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wr_end: wr_rdy=%b req_rdy=%b expected 0 1", wr_rdy, req_rdy);
    end
  endtask

  task automatic read_burst(input int base, input bit stall, input bit hold);
    int hs = 0;
    int cyc = 0;
    int a;
    wr_vld  = 1'b1;
    wr_data = 8'h5A;
    issue(1'b1, base, hold);
    wait_latency(1'b1);
    while (hs < 32 && cyc < 300) begin
      rd_rdy = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      a = (base + hs) % 1024;
      checks++;
      if (rd_vld !== 1'b1 || rd_data !== exp_mem[a] || rd_last !== (hs == 31)) begin
        errors++;
        $display("[TB] FAIL rd_beat: beat %0d vld=%b data=%h last=%b expected 1 %h %b",
                 hs, rd_vld, rd_data, rd_last, exp_mem[a], (hs == 31));
      end
      tick();
      if (rd_rdy) hs++;
      cyc++;
    end
    rd_rdy = 1'b0;
    wr_vld = 1'b0;
    checks++;
    if (hs != 32) begin
      errors++;
      $display("[TB] FAIL rd_timeout: %0d handshakes, expected 32", hs);
    end
    checks++;
    if (rd_vld !== 1'b0 || rd_last !== 1'b0 || rd_data !== 8'h00 || req_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rd_end: vld=%b last=%b data=%h req_rdy=%b expected 0 0 00 1",
               rd_vld, rd_last, rd_data, req_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (req_rdy !== 1'b1 || rd_vld !== 1'b0 || rd_last !== 1'b0 || rd_data !== 8'h00 ||
        wr_rdy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: req_rdy=%b rd_vld=%b rd_last=%b rd_data=%h wr_rdy=%b err=%b expected 1 0 0 00 0 0",
               req_rdy, rd_vld, rd_last, rd_data, wr_rdy, err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    write_burst(0, 0, -1, -1);
    read_burst(0, 1'b0, 1'b0);
  endtask

  task automatic test_read_stall();
    read_burst(0, 1'b1, 1'b0);
  endtask

  task automatic test_write_gap();
    write_burst(64, 8'hA0, 12, -1);
    read_burst(64, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    write_burst(1008, 8'h40, -1, -1);
    read_burst(1008, 1'b0, 1'b0);
    read_burst(0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    write_burst(128, 8'h10, -1, -1);
    write_burst(128, 8'hC0, -1, 10);
    for (int i = 0; i < 10; i++) exp_mem[128 + i] = 8'(8'hC0 + i);
    read_burst(128, 1'b0, 1'b0);
  endtask

  task automatic test_misaligned();
`ifdef DRAM_ALIGN_CHECK_EN
    issue(1'b0, 5, 1'b0);
    checks++;
    if (err !== 1'b1 || req_rdy !== 1'b1 || wr_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_pulse: err=%b req_rdy=%b wr_rdy=%b expected 1 1 0", err, req_rdy, wr_rdy);
    end
    wr_vld  = 1'b1;
    wr_data = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (err !== 1'b0 || wr_rdy !== 1'b0 || rd_vld !== 1'b0) begin
        errors++;
        $display("[TB] FAIL err_after: cycle %0d err=%b wr_rdy=%b rd_vld=%b expected 0 0 0",
                 i, err, wr_rdy, rd_vld);
      end
    end
    wr_vld = 1'b0;
    read_burst(0, 1'b0, 1'b0);
`else
    write_burst(5, 8'h70, -1, -1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_tied: err=%b expected 0", err);
    end
    read_burst(5, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_back_to_back();
    read_burst(0, 1'b0, 1'b1);
    tick();
    checks++;
    if (req_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_accept: req_rdy=%b expected 0", req_rdy);
    end
    req_vld = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (req_rdy !== 1'b1 || rd_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_abort: req_rdy=%b rd_vld=%b expected 1 0", req_rdy, rd_vld);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_read_stall();
    test_write_gap();
    test_wrap();
    test_reset_abort();
    test_misaligned();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
